// File: rtl/alu_64_bit.sv
// ---------------------------------------------------------------------------
// alu_64_bit
// 64-bit integer ALU for the execute stage. Operands and opcode are decoded
// combinationally; result and flags are registered (one cycle of latency).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       operands/opcode valid this cycle
//   a, b           operands (shifts use b[5:0] only)
//   opcode         operation select (4 bits)
//   out_valid      registered result valid
//   result         registered result
//   carry_flag     registered carry (ADD) / borrow (SUB)
//   overflow_flag  registered signed overflow (ADD/SUB)
//   zero_flag      registered (result == 0)
//   illegal_op     registered illegal-opcode indicator (only with
//                  ALU_ILLEGAL_OP_EN defined)
//
// Build option: define ALU_ILLEGAL_OP_EN to add the illegal_op output.
// ---------------------------------------------------------------------------
module alu_64_bit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      opcode,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            carry_flag,
  output logic            overflow_flag,
  output logic            zero_flag
`ifdef ALU_ILLEGAL_OP_EN
  ,
  output logic            illegal_op
`endif
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  // Shared adder: SUB and the set-less-than compares run through a + ~b + 1.
  logic            use_sub;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] add_res;
  logic            carry_out;
  logic            borrow;
  logic            add_ovf;
  logic            slt_bit;

  assign use_sub   = (opcode == OP_SUB) || (opcode == OP_SLT) || (opcode == OP_SLTU);
  assign b_eff     = use_sub ? ~b : b;
  assign sum       = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, use_sub};
  assign add_res   = sum[XLEN-1:0];
  assign carry_out = sum[XLEN];
  assign borrow    = ~carry_out;
  // With b inverted for SUB, "same sign of a and b_eff" covers both the ADD
  // and the SUB overflow rule.
  assign add_ovf   = (a[XLEN-1] == b_eff[XLEN-1]) && (add_res[XLEN-1] != a[XLEN-1]);
  assign slt_bit   = add_res[XLEN-1] ^ add_ovf;

  // Barrel shifter: right-shift core; left shifts reverse the operand on the
  // way in and out so one set of stages serves all three shift opcodes.
  logic [5:0]      shamt;
  logic            shl;
  logic            fill;
  logic [XLEN-1:0] s0, s1, s2, s3, s4, s5, s6;
  logic [XLEN-1:0] sh_out;

  assign shamt  = b[5:0];
  assign shl    = (opcode == OP_SLL);
  assign fill   = (opcode == OP_SRA) & a[XLEN-1];
  assign s0     = shl ? bit_rev(a) : a;
  assign s1     = shamt[0] ? {fill, s0[XLEN-1:1]}         : s0;
  assign s2     = shamt[1] ? {{2{fill}},  s1[XLEN-1:2]}   : s1;
  assign s3     = shamt[2] ? {{4{fill}},  s2[XLEN-1:4]}   : s2;
  assign s4     = shamt[3] ? {{8{fill}},  s3[XLEN-1:8]}   : s3;
  assign s5     = shamt[4] ? {{16{fill}}, s4[XLEN-1:16]}  : s4;
  assign s6     = shamt[5] ? {{32{fill}}, s5[XLEN-1:32]}  : s5;
  assign sh_out = shl ? bit_rev(s6) : s6;

  logic [XLEN-1:0] alu_res;
  logic            alu_c;
  logic            alu_o;
  logic            alu_legal;

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_o     = 1'b0;
    alu_legal = 1'b1;
    case (opcode)
      OP_ADD: begin
        alu_res = add_res;
        alu_c   = carry_out;
        alu_o   = add_ovf;
      end
      OP_SUB: begin
        alu_res = add_res;
        alu_c   = borrow;
        alu_o   = add_ovf;
      end
      OP_SLL, OP_SRL, OP_SRA: alu_res = sh_out;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, borrow};
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      result        <= '0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result        <= alu_res;
        carry_flag    <= alu_c;
        overflow_flag <= alu_o;
        zero_flag     <= (alu_res == '0);
      end
    end
  end

`ifdef ALU_ILLEGAL_OP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        illegal_op <= 1'b0;
    else if (in_valid) illegal_op <= ~alu_legal;
  end
`else
  logic unused_legal;
  assign unused_legal = alu_legal;
`endif

endmodule

// File: tb/tb_alu_64_bit.sv
// Directed testbench for alu_64_bit with hand-computed expected values.
module tb_alu_64_bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  opcode;
  logic        out_valid;
  logic [63:0] result;
  logic        carry_flag;
  logic        overflow_flag;
  logic        zero_flag;
`ifdef ALU_ILLEGAL_OP_EN
  logic        illegal_op;
`endif

  int checks   = 0;
  int failures = 0;

  alu_64_bit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .result        (result),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .zero_flag     (zero_flag)
`ifdef ALU_ILLEGAL_OP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one captured op at the falling edge, return 1 time unit after the
  // capturing rising edge.
  task automatic drive(input logic [3:0] op, input logic [63:0] va, input logic [63:0] vb);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 4'b0000;
    a        = 64'h0;
    b        = 64'h0;
    @(posedge clk);
    #1;
  endtask

  // Each vector: opcode, a, b, expected result, expected {C,O,Z}.
  task automatic run_vectors(input string name, input int n,
                             input logic [3:0] ops [16], input logic [63:0] va [16],
                             input logic [63:0] vb [16], input logic [63:0] er [16],
                             input logic [2:0] ef [16]);
    for (int i = 0; i < n; i++) begin
      drive(ops[i], va[i], vb[i]);
      checks++;
      if ({out_valid, result, carry_flag, overflow_flag, zero_flag} !== {1'b1, er[i], ef[i]}) begin
        failures++;
        $display("FAIL %s[%0d] op=%b: got v=%b r=%h czo=%b%b%b, expected v=1 r=%h czo=%b",
                 name, i, ops[i], out_valid, result, carry_flag, overflow_flag, zero_flag,
                 er[i], ef[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    opcode   = 4'b0000;
    a        = 64'h0;
    b        = 64'h0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, carry_flag, overflow_flag, zero_flag} !== {1'b0, 64'h0, 3'b001}) begin
      failures++;
      $display("FAIL reset_init: got v=%b r=%h czo=%b%b%b, expected v=0 r=0 czo=001",
               out_valid, result, carry_flag, overflow_flag, zero_flag);
    end
`ifdef ALU_ILLEGAL_OP_EN
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL reset_illegal: got %b, expected 0", illegal_op);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [3:0]  ops [16];
    logic [63:0] va [16], vb [16], er [16];
    logic [2:0]  ef [16];
    ops[0] = 4'b0000; va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;
    er[0] = 64'h8000_0000_0000_0000; ef[0] = 3'b010;
    ops[1] = 4'b0000; va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1;
    er[1] = 64'h0; ef[1] = 3'b101;
    ops[2] = 4'b0000; va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000;
    er[2] = 64'h0; ef[2] = 3'b111;
    ops[3] = 4'b0000; va[3] = 64'h0000_0001_2345_6789; vb[3] = 64'h0000_0000_1111_1111;
    er[3] = 64'h0000_0001_3456_789A; ef[3] = 3'b000;
    run_vectors("add", 4, ops, va, vb, er, ef);
  endtask

  task automatic test_sub();
    logic [3:0]  ops [16];
    logic [63:0] va [16], vb [16], er [16];
    logic [2:0]  ef [16];
    ops[0] = 4'b1000; va[0] = 64'h0; vb[0] = 64'h1;
    er[0] = 64'hFFFF_FFFF_FFFF_FFFF; ef[0] = 3'b100;
    ops[1] = 4'b1000; va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'h1;
    er[1] = 64'h7FFF_FFFF_FFFF_FFFF; ef[1] = 3'b010;
    ops[2] = 4'b1000; va[2] = 64'h1; vb[2] = 64'h1;
    er[2] = 64'h0; ef[2] = 3'b001;
    ops[3] = 4'b1000; va[3] = 64'h0; vb[3] = 64'h8000_0000_0000_0000;
    er[3] = 64'h8000_0000_0000_0000; ef[3] = 3'b110;
    ops[4] = 4'b1000; va[4] = 64'h100; vb[4] = 64'h1;
    er[4] = 64'hFF; ef[4] = 3'b000;
    run_vectors("sub", 5, ops, va, vb, er, ef);
  endtask

  task automatic test_shift();
    logic [3:0]  ops [16];
    logic [63:0] va [16], vb [16], er [16];
    logic [2:0]  ef [16];
    ops[0] = 4'b0001; va[0] = 64'h1; vb[0] = 64'h0000_DADA_0000_003F;
    er[0] = 64'h8000_0000_0000_0000; ef[0] = 3'b000;
    ops[1] = 4'b0101; va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd32;
    er[1] = 64'h0000_0000_FFFF_FFFF; ef[1] = 3'b000;
    ops[2] = 4'b1101; va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'd32;
    er[2] = 64'hFFFF_FFFF_8000_0000; ef[2] = 3'b000;
    ops[3] = 4'b0101; va[3] = 64'h1; vb[3] = 64'h000D_EAF0_0000_0000;
    er[3] = 64'h1; ef[3] = 3'b000;
    ops[4] = 4'b1101; va[4] = 64'h8000_0000_0000_0001; vb[4] = 64'd63;
    er[4] = 64'hFFFF_FFFF_FFFF_FFFF; ef[4] = 3'b000;
    ops[5] = 4'b0001; va[5] = 64'h0123_4567_89AB_CDEF; vb[5] = 64'd4;
    er[5] = 64'h1234_5678_9ABC_DEF0; ef[5] = 3'b000;
    ops[6] = 4'b1101; va[6] = 64'h7000_0000_0000_0000; vb[6] = 64'd60;
    er[6] = 64'h7; ef[6] = 3'b000;
    ops[7] = 4'b0101; va[7] = 64'h8000_0000_0000_0000; vb[7] = 64'd64;
    er[7] = 64'h8000_0000_0000_0000; ef[7] = 3'b000;
    run_vectors("shift", 8, ops, va, vb, er, ef);
  endtask

  task automatic test_compare_logic();
    logic [3:0]  ops [16];
    logic [63:0] va [16], vb [16], er [16];
    logic [2:0]  ef [16];
    ops[0] = 4'b0010; va[0] = 64'h8000_0000_0000_0000; vb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    er[0] = 64'h1; ef[0] = 3'b000;
    ops[1] = 4'b0011; va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h8000_0000_0000_0000;
    er[1] = 64'h1; ef[1] = 3'b000;
    ops[2] = 4'b0010; va[2] = 64'h0; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    er[2] = 64'h0; ef[2] = 3'b001;
    ops[3] = 4'b0111; va[3] = 64'h5555_5555_5555_5555; vb[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    er[3] = 64'h0; ef[3] = 3'b001;
    ops[4] = 4'b0011; va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'h1;
    er[4] = 64'h0; ef[4] = 3'b001;
    ops[5] = 4'b0100; va[5] = 64'h00FF_00FF_00FF_00FF; vb[5] = 64'h0F0F_0F0F_0F0F_0F0F;
    er[5] = 64'h0FF0_0FF0_0FF0_0FF0; ef[5] = 3'b000;
    ops[6] = 4'b0110; va[6] = 64'h1200; vb[6] = 64'h0034;
    er[6] = 64'h1234; ef[6] = 3'b000;
    ops[7] = 4'b0010; va[7] = 64'h7FFF_FFFF_FFFF_FFFF; vb[7] = 64'h8000_0000_0000_0000;
    er[7] = 64'h0; ef[7] = 3'b001;
    ops[8] = 4'b0010; va[8] = 64'hFFFF_FFFF_FFFF_FFFE; vb[8] = 64'h5;
    er[8] = 64'h1; ef[8] = 3'b000;
    run_vectors("cmp_logic", 9, ops, va, vb, er, ef);
  endtask

  task automatic test_illegal();
    logic [3:0]  ops [16];
    logic [63:0] va [16], vb [16], er [16];
    logic [2:0]  ef [16];
    ops[0] = 4'b1111; va[0] = 64'h5; vb[0] = 64'h3; er[0] = 64'h0; ef[0] = 3'b001;
    ops[1] = 4'b1001; va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1; er[1] = 64'h0; ef[1] = 3'b001;
    ops[2] = 4'b1010; va[2] = 64'h0; vb[2] = 64'h8000_0000_0000_0000; er[2] = 64'h0; ef[2] = 3'b001;
    run_vectors("illegal", 3, ops, va, vb, er, ef);
`ifdef ALU_ILLEGAL_OP_EN
    checks++;
    if (illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL illegal_flag_set: got %b, expected 1", illegal_op);
    end
    idle();
    checks++;
    if (illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL illegal_flag_hold: got %b, expected 1", illegal_op);
    end
    drive(4'b0000, 64'h2, 64'h3);
    checks++;
    if (illegal_op !== 1'b0 || result !== 64'h5) begin
      failures++;
      $display("FAIL illegal_flag_clear: got ill=%b r=%h, expected ill=0 r=5", illegal_op, result);
    end
`endif
  endtask

  task automatic test_back_to_back();
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pre_idle: got out_valid=%b, expected 0", out_valid);
    end
    drive(4'b0000, 64'd10, 64'd20);
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd30) begin
      failures++;
      $display("FAIL b2b_op0: got v=%b r=%h, expected v=1 r=1e", out_valid, result);
    end
    drive(4'b1000, 64'd10, 64'd20);
    checks++;
    if (out_valid !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFF6 || carry_flag !== 1'b1) begin
      failures++;
      $display("FAIL b2b_op1: got v=%b r=%h c=%b, expected v=1 r=fffffffffffffff6 c=1",
               out_valid, result, carry_flag);
    end
    drive(4'b0110, 64'hF0, 64'h0F);
    checks++;
    if (out_valid !== 1'b1 || result !== 64'hFF || carry_flag !== 1'b0) begin
      failures++;
      $display("FAIL b2b_op2: got v=%b r=%h c=%b, expected v=1 r=ff c=0", out_valid, result, carry_flag);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if ({out_valid, result, carry_flag, overflow_flag, zero_flag} !== {1'b0, 64'hFF, 3'b000}) begin
        failures++;
        $display("FAIL b2b_hold[%0d]: got v=%b r=%h czo=%b%b%b, expected v=0 r=ff czo=000",
                 i, out_valid, result, carry_flag, overflow_flag, zero_flag);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    // Clock is high here; dropping rst_n is not aligned to any rising edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, carry_flag, overflow_flag, zero_flag} !== {1'b0, 64'h0, 3'b001}) begin
      failures++;
      $display("FAIL reset_mid: got v=%b r=%h czo=%b%b%b, expected v=0 r=0 czo=001",
               out_valid, result, carry_flag, overflow_flag, zero_flag);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, zero_flag} !== {1'b0, 64'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_release: got v=%b r=%h z=%b, expected v=0 r=0 z=1",
               out_valid, result, zero_flag);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_compare_logic();
    test_illegal();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
